// File: rtl/vending_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : vending_controller_if
// Brief    : Coin sensor, datapath compare/strobes and vend command bundle.
// Revision : 1.0
// ============================================================================
interface vending_controller_if;
    logic c_i;
    logic tot_lt_s_i;
    logic tot_ld_o;
    logic tot_clr_o;
    logic d_o;
    logic busy_o;

    modport slave (
        input  c_i,
        input  tot_lt_s_i,
        output tot_ld_o,
        output tot_clr_o,
        output d_o,
        output busy_o
    );

    modport master (
        output c_i,
        output tot_lt_s_i,
        input  tot_ld_o,
        input  tot_clr_o,
        input  d_o,
        input  busy_o
    );
endinterface
`default_nettype wire

// File: rtl/vending_controller.sv
`default_nettype none
// ============================================================================
// Module   : vending_controller
// Brief    : Coin-accumulate / dispense Moore FSM driving an external datapath.
// Revision : 1.0
// ============================================================================
module vending_controller #(
    parameter int unsigned DISP_CYCLES = 4
) (
    input  wire logic             clk_i,
    input  wire logic             rst_ni,
    vending_controller_if.slave   bus
);

    typedef enum logic [1:0] {
        INIT = 2'd0,
        WAIT = 2'd1,
        ADD  = 2'd2,
        DISP = 2'd3
    } state_t;

    localparam logic [7:0] c_DISP_LOAD = 8'(DISP_CYCLES - 1);

    logic   r_sync1;
    logic   r_sync2;
    logic   r_sync3;
    state_t r_state;
    state_t w_next_state;
    logic [7:0] r_cnt;
    logic [7:0] w_next_cnt;
    logic   w_coin_evt;
    logic   w_tot_ld;
    logic   w_tot_clr;
    logic   w_disp;

    // Third flop gives edge history so a long coin level yields one event.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= bus.c_i;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_coin_evt = r_sync2 & ~r_sync3;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= INIT;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_tot_ld     = 1'b0;
        w_tot_clr    = 1'b0;
        w_disp       = 1'b0;
        case (r_state)
            INIT: begin
                w_tot_clr    = 1'b1;
                w_next_state = WAIT;
            end
            WAIT: begin
                // A coin arriving alongside "price reached" is added first.
                if (w_coin_evt) begin
                    w_next_state = ADD;
                end else if (!bus.tot_lt_s_i) begin
                    w_next_state = DISP;
                    w_next_cnt   = c_DISP_LOAD;
                end
            end
            ADD: begin
                w_tot_ld     = 1'b1;
                w_next_state = WAIT;
            end
            DISP: begin
                w_disp = 1'b1;
                if (r_cnt == 8'd0) begin
                    w_next_state = INIT;
                end else begin
                    w_next_cnt = r_cnt - 8'd1;
                end
            end
            default: begin
                w_next_state = INIT;
            end
        endcase
    end

    assign bus.tot_ld_o  = w_tot_ld;
    assign bus.tot_clr_o = w_tot_clr;
    assign bus.d_o       = w_disp;
    assign bus.busy_o    = w_disp;

endmodule
`default_nettype wire

// File: tb/tb_vending_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_vending_controller
// Brief    : Directed self-checking bench for vending_controller.
// Revision : 1.0
// ============================================================================
module tb_vending_controller;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   total = 0;
    int   price = 200;
    int   coin_val = 0;

    vending_controller_if bus0 ();
    vending_controller_if bus1 ();

    vending_controller #(.DISP_CYCLES(4)) dut0 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus0.slave)
    );

    vending_controller #(.DISP_CYCLES(1)) dut1 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus1.slave)
    );

    always #5 clk = ~clk;

    // Datapath model: running total compared against the price.
    always @(posedge clk) begin
        if (bus0.tot_clr_o)
            total <= 0;
        else if (bus0.tot_ld_o)
            total <= total + coin_val;
    end

    assign bus0.tot_lt_s_i = (total < price);
    assign bus1.tot_lt_s_i = 1'b0;
    assign bus1.c_i        = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check("excl_ld_clr", {31'd0, bus0.tot_ld_o & bus0.tot_clr_o}, 32'd0);
        check("excl_d_strobe", {31'd0, bus0.d_o & (bus0.tot_ld_o | bus0.tot_clr_o)}, 32'd0);
    endtask

    task automatic do_reset(input int new_price, input logic hold_c);
        rst_n     = 1'b0;
        bus0.c_i  = hold_c;
        price     = new_price;
        coin_val  = 50;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic coin_check(input int val, input string tag);
        coin_val = val;
        bus0.c_i = 1'b1;
        tick(); check({tag, "_ld_k"},   {31'd0, bus0.tot_ld_o}, 32'd0);
        tick(); check({tag, "_ld_k1"},  {31'd0, bus0.tot_ld_o}, 32'd0);
        tick(); check({tag, "_ld_k2"},  {31'd0, bus0.tot_ld_o}, 32'd1);
        tick(); check({tag, "_ld_k3"},  {31'd0, bus0.tot_ld_o}, 32'd0);
        bus0.c_i = 1'b0;
    endtask

    initial begin
        int dc;
        int lc;
        logic [7:0] exp_d0;
        logic [7:0] exp_clr0;
        logic [7:0] exp_d1;

        // Reset state
        bus0.c_i = 1'b0;
        rst_n    = 1'b0;
        tick();
        check("rst_clr",  {31'd0, bus0.tot_clr_o}, 32'd1);
        check("rst_ld",   {31'd0, bus0.tot_ld_o},  32'd0);
        check("rst_d",    {31'd0, bus0.d_o},       32'd0);
        check("rst_busy", {31'd0, bus0.busy_o},    32'd0);
        tick();
        rst_n = 1'b1;
        check("rel_init_clr", {31'd0, bus0.tot_clr_o}, 32'd1);
        tick();
        check("rel_wait_clr", {31'd0, bus0.tot_clr_o}, 32'd0);

        // Price 200: coins 50, 50, 100 spaced ten cycles apart
        coin_check(50, "c50a");
        repeat (6) tick();
        coin_check(50, "c50b");
        repeat (6) tick();
        check("pre_disp_d", {31'd0, bus0.d_o}, 32'd0);
        coin_check(100, "c100");
        check("post_add_d", {31'd0, bus0.d_o}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("vend_d",    {31'd0, bus0.d_o},    32'd1);
            check("vend_busy", {31'd0, bus0.busy_o}, 32'd1);
        end
        tick();
        check("vend_end_d",   {31'd0, bus0.d_o},       32'd0);
        check("vend_end_clr", {31'd0, bus0.tot_clr_o}, 32'd1);
        tick();
        check("vend_wait_clr", {31'd0, bus0.tot_clr_o}, 32'd0);
        tick();
        check("vend_wait_d", {31'd0, bus0.d_o}, 32'd0);

        // Long coin level yields a single load
        do_reset(200, 1'b0);
        tick();
        lc = 0;
        bus0.c_i = 1'b1;
        repeat (20) begin tick(); lc += int'(bus0.tot_ld_o); end
        bus0.c_i = 1'b0;
        repeat (5) begin tick(); lc += int'(bus0.tot_ld_o); end
        check("long_coin_loads", lc, 32'd1);

        // Coin inserted during a vend is discarded
        do_reset(100, 1'b0);
        tick();
        coin_check(100, "c100p");
        tick();
        check("disp_coin_d1", {31'd0, bus0.d_o}, 32'd1);
        bus0.c_i = 1'b1;
        dc = 1;
        lc = 0;
        repeat (8) begin
            tick();
            dc += int'(bus0.d_o);
            lc += int'(bus0.tot_ld_o);
        end
        bus0.c_i = 1'b0;
        check("disp_coin_width", dc, 32'd4);
        check("disp_coin_loads", lc, 32'd0);

        // Coin held across reset release gives exactly one event
        do_reset(200, 1'b1);
        lc = 0;
        repeat (15) begin tick(); lc += int'(bus0.tot_ld_o); end
        bus0.c_i = 1'b0;
        check("held_rst_loads", lc, 32'd1);

        // Price 0: continuous vending; DISP_CYCLES=1 instance alongside
        do_reset(0, 1'b0);
        check("p0_init_clr0", {31'd0, bus0.tot_clr_o}, 32'd1);
        check("p0_init_clr1", {31'd0, bus1.tot_clr_o}, 32'd1);
        exp_d0   = 8'b1001_1110;
        exp_clr0 = 8'b0010_0000;
        exp_d1   = 8'b1001_0010;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("p0_d0",   {31'd0, bus0.d_o},       {31'd0, exp_d0[i]});
            check("p0_clr0", {31'd0, bus0.tot_clr_o}, {31'd0, exp_clr0[i]});
            check("p0_d1",   {31'd0, bus1.d_o},       {31'd0, exp_d1[i]});
        end

        // Reset during DISP cycle 2 aborts the vend immediately
        tick();
        check("abort_pre_d", {31'd0, bus0.d_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_d",    {31'd0, bus0.d_o},       32'd0);
        check("abort_busy", {31'd0, bus0.busy_o},    32'd0);
        check("abort_clr",  {31'd0, bus0.tot_clr_o}, 32'd1);
        tick();
        rst_n = 1'b1;
        check("abort_rel_clr", {31'd0, bus0.tot_clr_o}, 32'd1);
        tick();
        check("abort_wait_clr", {31'd0, bus0.tot_clr_o}, 32'd0);
        check("abort_wait_d",   {31'd0, bus0.d_o},       32'd0);
        tick();
        check("abort_redisp_d", {31'd0, bus0.d_o}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vending_controller.md
VENDING_CONTROLLER -- requirements
Module: vending_controller

Interface
REQ-001 Parameter DISP_CYCLES, default 4, SHALL set the number of cycles d_o is held high per dispense; legal range 1..255.
REQ-002 clk_i  input  1  sole clock; all state SHALL change on its rising edge only.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 c_i  input  1  coin-present level from the coin sensor; asynchronous to clk_i.
REQ-005 tot_lt_s_i  input  1  datapath compare flag, high while running total < price.
REQ-006 tot_ld_o  output  1  datapath load strobe (total <= total + coin amount).
REQ-007 tot_clr_o  output  1  datapath clear strobe (total <= 0).
REQ-008 d_o  output  1  dispense command to the vend mechanism.
REQ-009 busy_o  output  1  high while in DISP; coins are not accepted.

Function
REQ-010 c_i SHALL pass through a 2-flop synchronizer, then a third history flop.
REQ-011 coin_evt SHALL be sync2 & ~sync3: one cycle per c_i rising edge, regardless of how long c_i stays high.
REQ-012 FSM states: INIT, WAIT, ADD, DISP.
REQ-013 All outputs SHALL be Moore, decoded from state only, with no combinational path from any input.
REQ-014 INIT: tot_clr_o=1; next state WAIT unconditionally.
REQ-015 WAIT: if coin_evt, go to ADD.
REQ-016 WAIT: else if tot_lt_s_i=0, go to DISP and load the dispense counter with DISP_CYCLES-1.
REQ-017 WAIT: else remain in WAIT.
REQ-018 If coin_evt and tot_lt_s_i=0 occur together in WAIT, coin_evt SHALL win: the coin is added before the dispense.
REQ-019 ADD: tot_ld_o=1 for exactly one cycle; next state WAIT unconditionally.
REQ-020 tot_lt_s_i SHALL first be evaluated in the WAIT cycle after ADD, when the datapath total is already updated.
REQ-021 DISP: d_o=1 and busy_o=1.
REQ-022 DISP: the counter SHALL decrement each cycle; when it is 0, next state INIT.
REQ-023 DISP: d_o SHALL be high for exactly DISP_CYCLES consecutive cycles.
REQ-024 coin_evt in DISP or INIT SHALL be discarded; no tot_ld_o results.
REQ-025 Coin latency: c_i rises before edge k -> state ADD after edge k+2 -> tot_ld_o high for cycle k+2..k+3.
REQ-026 A second c_i rising edge SHALL be accepted only if at least 2 cycles separate the two coin_evt pulses (ADD->WAIT turnaround).
REQ-027 A coin_evt arriving while in ADD SHALL be lost; a sensor pulse low-time of at least 2 cycles is required.
REQ-028 tot_ld_o and tot_clr_o SHALL never be high in the same cycle.
REQ-029 d_o SHALL never be high in the same cycle as tot_ld_o or tot_clr_o.
REQ-030 Counter width SHALL be 8 bits; no wrap-around SHALL occur since the load is at most 254.

Reset
REQ-031 rst_ni=0 SHALL immediately (asynchronously) force state INIT, dispense counter 0, and all three coin flops 0.
REQ-032 Output values during reset: tot_clr_o=1, tot_ld_o=0, d_o=0, busy_o=0.
REQ-033 Reset asserted mid-ADD or mid-DISP SHALL abort the operation; the pending load or remaining dispense cycles are dropped.
REQ-034 First cycle after release: state INIT; WAIT from the second cycle.
REQ-035 If c_i is held high across reset release, it SHALL produce exactly one coin_evt after release.

Verification
REQ-036 Price 200; coins 50, 50, 100 spaced 10 cycles apart -> three single-cycle tot_ld_o pulses, each 3 cycles after its c_i rise; d_o high 4 cycles after the third; then tot_clr_o=1 for 1 cycle; then WAIT.
REQ-037 c_i held high for 20 cycles -> exactly one tot_ld_o pulse.
REQ-038 Price 0 after reset -> INIT, WAIT, then DISP: d_o=1 for 4 cycles, then INIT, repeating continuously.
REQ-039 Coin edge during DISP, with price 100 and a single coin 100 -> no tot_ld_o for the coin inserted during DISP; d_o width is still 4.
REQ-040 rst_ni pulled low for 1 cycle at DISP cycle 2 -> d_o=0 immediately, tot_clr_o=1 during reset; after release the sequence is INIT then WAIT.
REQ-041 DISP_CYCLES=1 -> d_o is high for exactly 1 cycle per vend.
